regfile_mp: RTL

- Parametrised multi-port integer register file; successor to the single-write, two-read core register file.
- Sits between decode/issue (read ports, busy query) and writeback (multiple write ports, e.g. ALU and LSU).
- Adds configurable width, depth and port counts, plus a per-register busy scoreboard with issue/flush control.
- Writes are clocked; reads are combinational.

---
 rtl/regfile_mp.sv | 129 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with busy scoreboard.
//
// Writes and scoreboard updates are clocked; reads are combinational.
// Optional feature, enabled by defining REGFILE_BYPASS_EN: same-cycle write-to-read
// forwarding of data and of the busy-clear on every read port.
// Default build (macro undefined): read paths are a pure array mux.

module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NRD*$clog2(NREG)-1:0] rd_idx,
    output logic [NRD*XLEN-1:0]       rd_data,
    output logic [NRD-1:0]            rd_busy,
    input  logic [NWR-1:0]            wr_en,
    input  logic [NWR*$clog2(NREG)-1:0] wr_idx,
    input  logic [NWR*XLEN-1:0]       wr_data,
    input  logic                      iss_en,
    input  logic [$clog2(NREG)-1:0]   iss_idx,
    input  logic                      flush
);

    localparam int unsigned AW = $clog2(NREG);

    // Architectural state
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Unpacked views of the flat port buses
    logic [AW-1:0]   rd_idx_a  [NRD];
    logic [XLEN-1:0] rd_data_a [NRD];
    logic [AW-1:0]   wr_idx_a  [NWR];
    logic [XLEN-1:0] wr_data_a [NWR];

    // Qualified write enables and issue (range and zero-register filtered)
    logic [NWR-1:0] wr_ok;
    logic           iss_ok;

    // Indices at or above NREG only exist when NREG is not a power of two.
    function automatic logic idx_in_range(input logic [AW-1:0] idx);
        return 32'(idx) < NREG;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    for (genvar k = 0; k < NRD; k++) begin : gen_rd_ports
        assign rd_idx_a[k]              = rd_idx[k*AW +: AW];
        assign rd_data[k*XLEN +: XLEN]  = rd_data_a[k];
    end

    for (genvar p = 0; p < NWR; p++) begin : gen_wr_ports
        assign wr_idx_a[p]  = wr_idx[p*AW +: AW];
        assign wr_data_a[p] = wr_data[p*XLEN +: XLEN];
    end

    // Qualify writes and issue: drop out-of-range targets and the hardwired zero register
    always_comb begin : qualify
        wr_ok = '0;
        for (int p = 0; p < NWR; p++) begin
            wr_ok[p] = wr_en[p] && idx_in_range(wr_idx_a[p]) && !is_zero_reg(wr_idx_a[p]);
        end
        iss_ok = iss_en && idx_in_range(iss_idx) && !is_zero_reg(iss_idx);
    end

    // Next state: ascending port order makes the highest-numbered writer win;
    // issue is applied after write-clears so a new producer keeps the bit set.
    always_comb begin : next_state
        regs_d = regs_q;
        busy_d = busy_q;
        for (int p = 0; p < NWR; p++) begin
            if (wr_ok[p]) begin
                regs_d[wr_idx_a[p]] = wr_data_a[p];
                busy_d[wr_idx_a[p]] = 1'b0;
            end
        end
        if (iss_ok) begin
            busy_d[iss_idx] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    // State registers with synchronous reset taking precedence over all updates
    always_ff @(posedge clk) begin : state_regs
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Combinational read ports: array mux, optional forwarding, zero/out-of-range forced to 0
    always_comb begin : read_path
        for (int k = 0; k < NRD; k++) begin
            rd_data_a[k] = '0;
            rd_busy[k]   = 1'b0;
            if (idx_in_range(rd_idx_a[k]) && !is_zero_reg(rd_idx_a[k])) begin
                rd_data_a[k] = regs_q[rd_idx_a[k]];
                rd_busy[k]   = busy_q[rd_idx_a[k]];
`ifdef REGFILE_BYPASS_EN
                // Later ports overwrite earlier matches, so the highest matching port wins.
                for (int p = 0; p < NWR; p++) begin
                    if (wr_ok[p] && (wr_idx_a[p] == rd_idx_a[k])) begin
                        rd_data_a[k] = wr_data_a[p];
                        if (!(iss_ok && (iss_idx == rd_idx_a[k]))) begin
                            rd_busy[k] = 1'b0;
                        end
                    end
                end
`endif
            end
        end
    end

endmodule
